// File: rtl/vctcxo_dac_writer_pkg.sv
// ---------------------------------------------------------------------------
// vctcxo_dac_writer_pkg
// Shared definitions for the VCTCXO DAC writer: controller state encoding,
// serial frame geometry and the default DAC command nibble.
// No ports (package).
// ---------------------------------------------------------------------------
package vctcxo_dac_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_GAP
  } dac_state_e;

  localparam int unsigned FRAME_W      = 24;
  localparam int unsigned HALF_PERIODS = 2 * FRAME_W;
  localparam logic [3:0]  DEFAULT_CMD  = 4'b0011;

  // Frame layout: command nibble, four don't-care zero bits, 16-bit code.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]  cmd,
                                                     input logic [15:0] code);
    return {cmd, 4'b0000, code};
  endfunction

endpackage

// File: rtl/vctcxo_dac_writer_timer.sv
// ---------------------------------------------------------------------------
// dac_spi_timer
// Loadable down-counter used for the SCLK half-periods and the inter-frame
// gap. After a load of N-1 the tick is high on the N-th cycle; the counter
// then rests at zero until the next load.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset
//   load     - load load_val into the counter this edge
//   load_val - reload value (period minus one)
//   tick     - high while the counter sits at zero
// ---------------------------------------------------------------------------
module dac_spi_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Decrement saturates at zero so an unserviced tick never wraps around.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/vctcxo_dac_writer.sv
// ---------------------------------------------------------------------------
// vctcxo_dac_writer
// Serialises the discipline loop's 16-bit DAC code into a 24-bit SPI write
// frame whenever the code changes (and once after every reset). Updates that
// arrive while a frame or gap is in progress collapse into the value present
// when the writer becomes idle again.
// Ports:
//   clk    - 200 MHz loop clock
//   rst    - synchronous active-high reset
//   data   - requested DAC code, sampled every clk
//   sclk   - SPI serial clock (idles low)
//   mosi   - SPI serial data, MSB first
//   sync_n - active-low frame select
//   busy   - high in every state except IDLE
//   done   - one-cycle pulse as each frame completes
// ---------------------------------------------------------------------------
module vctcxo_dac_writer
  import vctcxo_dac_writer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [3:0]  CMD     = DEFAULT_CMD,
  parameter int unsigned MIN_GAP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  output logic        sclk,
  output logic        mosi,
  output logic        sync_n,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP - 1);
  localparam logic [5:0] LAST_HP  = 6'(HALF_PERIODS - 1);

  dac_state_e         state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [15:0]        last_sent_q, last_sent_d;
  logic               pending_q, pending_d;
  logic [5:0]         hp_cnt_q, hp_cnt_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               sync_n_q, sync_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               tmr_load;
  logic [7:0]         tmr_val;
  logic               tick;
  logic [FRAME_W-1:0] new_frame;

  assign new_frame = build_frame(CMD, data);

  dac_spi_timer #(.WIDTH(8)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick)
  );

  // Every non-idle state ends on a timer tick, and every tick either reloads
  // the timer or returns to IDLE, so a stale tick is never acted upon.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    last_sent_d = last_sent_q;
    pending_d   = pending_q;
    hp_cnt_d    = hp_cnt_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    sync_n_d    = sync_n_q;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = DIV_LOAD;

    unique case (state_q)
      ST_IDLE: begin
        if ((data != last_sent_q) || pending_q) begin
          shreg_d     = new_frame;
          mosi_d      = new_frame[FRAME_W-1];
          last_sent_d = data;
          pending_d   = 1'b0;
          sync_n_d    = 1'b0;
          sclk_d      = 1'b0;
          hp_cnt_d    = '0;
          tmr_load    = 1'b1;
          state_d     = ST_LEAD;
        end
      end

      ST_LEAD: begin
        if (tick) begin
          tmr_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          tmr_load = 1'b1;
          if (hp_cnt_q == LAST_HP) begin
            sclk_d  = 1'b0;
            state_d = ST_TRAIL;
          end else begin
            hp_cnt_d = hp_cnt_q + 6'd1;
            sclk_d   = ~sclk_q;
            // Falling edge of sclk: present the next bit.
            if (sclk_q) begin
              shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
              mosi_d  = shreg_q[FRAME_W-2];
            end
          end
        end
      end

      ST_TRAIL: begin
        if (tick) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          sync_n_d = 1'b1;
          mosi_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_GAP;
        end
      end

      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      last_sent_q <= 16'h0000;
      pending_q   <= 1'b1;
      hp_cnt_q    <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      sync_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      last_sent_q <= last_sent_d;
      pending_q   <= pending_d;
      hp_cnt_q    <= hp_cnt_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      sync_n_q    <= sync_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sclk   = sclk_q;
  assign mosi   = mosi_q;
  assign sync_n = sync_n_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_vctcxo_dac_writer.sv
// ---------------------------------------------------------------------------
// tb_vctcxo_dac_writer
// Drives directed and random code sequences into the DAC writer and compares
// its serial outputs every cycle against a timeline model of when frames
// start and how long each phase lasts, plus a serial decoder that rebuilds
// each transmitted word.
// ---------------------------------------------------------------------------
module tb_vctcxo_dac_writer;

  localparam int D  = 4;
  localparam int G  = 16;
  localparam int FL = 50 * D;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic        sclk, mosi, sync_n, busy, done;

  always #5 clk = ~clk;

  vctcxo_dac_writer #(
    .CLK_DIV (D),
    .CMD     (4'b0011),
    .MIN_GAP (G)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .sclk   (sclk),
    .mosi   (mosi),
    .sync_n (sync_n),
    .busy   (busy),
    .done   (done)
  );

  int n_vectors = 0;
  int n_fail    = 0;

  // Reference model: edge index of the current frame start and the earliest
  // edge at which the writer may begin another frame.
  int          cyc         = 0;
  int          m_start     = -1;
  int          m_free_at   = 0;
  logic [15:0] m_last      = 16'h0000;
  logic        m_pending   = 1'b1;
  logic [23:0] m_frame     = 24'h0;
  logic        m_rst       = 1'b0;

  // Serial decoder state.
  logic        prev_sclk   = 1'b0;
  logic        prev_sync   = 1'b1;
  int          rise_cnt    = 0;
  int          low_cnt     = 0;
  int          fall_cnt    = 0;
  int          high_run    = 0;
  logic [23:0] dec_word    = 24'h0;
  logic [23:0] last_decoded = 24'h0;
  logic        gap_check   = 1'b0;
  logic        gap_valid   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelEdge(input logic [15:0] d, input logic r);
    m_rst = r;
    if (r) begin
      m_start   = -1;
      m_last    = 16'h0000;
      m_pending = 1'b1;
      m_free_at = cyc + 1;
    end else if (cyc >= m_free_at && (d != m_last || m_pending)) begin
      m_start   = cyc;
      m_frame   = {4'b0011, 4'b0000, d};
      m_last    = d;
      m_pending = 1'b0;
      m_free_at = cyc + FL + G + 1;
    end
  endtask

  task automatic checkCycle();
    int   k;
    int   idx;
    logic e_sync, e_sclk, e_done, e_busy;
    k      = (m_start >= 0) ? (cyc - m_start) : 1000000;
    e_sync = 1'b1;
    e_sclk = 1'b0;
    e_done = 1'b0;
    e_busy = 1'b0;
    if (m_rst) begin
      checkOutput("reset_mosi", mosi, 1'b0);
    end else if (k < FL) begin
      e_sync = 1'b0;
      e_busy = 1'b1;
      if (k >= D && k < 49 * D) e_sclk = (((k - D) / D) % 2) == 1;
      if (k < 49 * D) begin
        idx = (k < D) ? 23 : 23 - ((k - D) / D) / 2;
        checkOutput("mosi", mosi, m_frame[idx]);
      end
    end else if (k < FL + G) begin
      e_busy = 1'b1;
      e_done = (k == FL);
    end
    checkOutput("sync_n", sync_n, e_sync);
    checkOutput("sclk", sclk, e_sclk);
    checkOutput("done", done, e_done);
    checkOutput("busy", busy, e_busy);
  endtask

  task automatic observe();
    if (prev_sync && !sync_n) begin
      fall_cnt++;
      rise_cnt = 0;
      low_cnt  = 0;
      dec_word = 24'h0;
      if (gap_check && gap_valid) checkOutput("gap_len", high_run, G + 1);
    end
    if (!sync_n) begin
      low_cnt++;
      high_run = 0;
      if (!prev_sclk && sclk) begin
        rise_cnt++;
        dec_word = {dec_word[22:0], mosi};
      end
    end else begin
      high_run++;
    end
    if (done) begin
      checkOutput("frame_rises", rise_cnt, 24);
      checkOutput("frame_word", dec_word, m_frame);
      checkOutput("sync_low_len", low_cnt, FL);
      last_decoded = dec_word;
      gap_valid    = 1'b1;
    end
    if (rst) gap_valid = 1'b0;
    prev_sclk = sclk;
    prev_sync = sync_n;
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic r);
    data = d;
    rst  = r;
    @(posedge clk);
    cyc++;
    modelEdge(d, r);
    @(negedge clk);
    checkCycle();
    observe();
  endtask

  initial begin
    int          f0;
    int          n;
    int          hold;
    logic [15:0] d;
    logic        r;

    rst  = 1'b1;
    data = 16'h8000;

    // Reset, then the mandatory post-reset frame.
    repeat (3) applyStimulus(16'h8000, 1'b1);
    checkOutput("reset_no_frames", fall_cnt, 0);
    f0 = fall_cnt;
    repeat (FL + G + 10) applyStimulus(16'h8000, 1'b0);
    checkOutput("post_reset_frames", fall_cnt - f0, 1);
    checkOutput("post_reset_word", last_decoded, 24'h308000);

    // Steady input produces no further frames.
    f0 = fall_cnt;
    repeat (10000) applyStimulus(16'h8000, 1'b0);
    checkOutput("steady_frames", fall_cnt - f0, 0);

    // Several updates during one frame collapse to the last one.
    f0 = fall_cnt;
    repeat (31) applyStimulus(16'h1111, 1'b0);
    repeat (30) applyStimulus(16'h1234, 1'b0);
    repeat (30) applyStimulus(16'h5678, 1'b0);
    repeat (2 * (FL + G)) applyStimulus(16'h9ABC, 1'b0);
    checkOutput("midframe_frames", fall_cnt - f0, 2);
    checkOutput("midframe_word", last_decoded, 24'h309ABC);

    // A change that reverts before idle sends nothing extra.
    f0 = fall_cnt;
    repeat (50) applyStimulus(16'h4444, 1'b0);
    repeat (50) applyStimulus(16'h7777, 1'b0);
    repeat (2 * (FL + G)) applyStimulus(16'h4444, 1'b0);
    checkOutput("revert_frames", fall_cnt - f0, 1);
    checkOutput("revert_word", last_decoded, 24'h304444);

    // Reset at the 10th sclk rise aborts the frame; one resend follows.
    f0 = fall_cnt;
    n  = 0;
    applyStimulus(16'hBEEF, 1'b0);
    while (rise_cnt != 10 && n < 1000) begin
      applyStimulus(16'hBEEF, 1'b0);
      n++;
    end
    checkOutput("rise10_reached", rise_cnt == 10, 1'b1);
    applyStimulus(16'hBEEF, 1'b1);
    checkOutput("abort_sync_n", sync_n, 1'b1);
    repeat (2 * (FL + G)) applyStimulus(16'hBEEF, 1'b0);
    checkOutput("abort_frames", fall_cnt - f0, 2);
    checkOutput("abort_resend_word", last_decoded, 24'h30BEEF);

    // A zero code is still sent once after reset.
    repeat (2) applyStimulus(16'h0000, 1'b1);
    f0 = fall_cnt;
    repeat (FL + G + 5) applyStimulus(16'h0000, 1'b0);
    checkOutput("zero_frames", fall_cnt - f0, 1);
    checkOutput("zero_word", last_decoded, 24'h300000);

    // Continuously changing data: frames back to back with the minimum gap.
    gap_valid = 1'b0;
    gap_check = 1'b1;
    repeat (3 * (FL + G + 1) + 5) begin
      d = 16'($urandom);
      if (d == m_last) d = ~d;
      applyStimulus(d, 1'b0);
    end
    gap_check = 1'b0;

    // Random holds, reverts and occasional resets.
    for (int i = 0; i < 40; i++) begin
      d    = ($urandom_range(0, 2) == 0) ? m_last : 16'($urandom);
      hold = $urandom_range(1, 300);
      r    = ($urandom_range(0, 9) == 0);
      if (r) repeat ($urandom_range(1, 3)) applyStimulus(d, 1'b1);
      repeat (hold) applyStimulus(d, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
    $finish;
  end

endmodule

// File: doc/vctcxo_dac_writer.md
VCTCXO_DAC_WRITER -- requirements
Module: vctcxo_dac_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL have parameter CMD, default 4'b0011, meaning the DAC command nibble (write and update).
REQ-003 SHALL have parameter MIN_GAP, default 16, meaning the number of clk cycles SYNC_N stays high between frames; legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, the 200 MHz loop clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port data, input, 16 bits: requested DAC code from the discipline loop, sampled every clk.
REQ-007 SHALL have port sclk, output, 1 bit: serial clock to the DAC.
REQ-008 SHALL have port mosi, output, 1 bit: serial data to the DAC.
REQ-009 SHALL have port sync_n, output, 1 bit: active-low frame select.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame or the inter-frame gap is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-012 SHALL implement the states IDLE, LEAD, SHIFT, TRAIL and GAP; busy SHALL be low only in IDLE.
REQ-013 In IDLE, when data differs from last_sent or send_pending is set, the block SHALL, on the same edge:
- latch {CMD, 4'b0000, data} into a 24-bit shift register;
- store data as last_sent;
- clear send_pending;
- drive sync_n low;
- enter LEAD.
REQ-014 LEAD SHALL last CLK_DIV cycles, with sclk low and mosi equal to frame bit 23.
REQ-015 SHIFT SHALL consist of 48 half-periods of CLK_DIV cycles each:
- sclk toggles at the end of each half-period, starting low;
- mosi shifts to the next bit on each sclk falling edge, MSB first;
- exactly 24 sclk rising edges occur per frame.
REQ-016 TRAIL SHALL last CLK_DIV cycles with sclk low and sync_n low; on exit, sync_n SHALL go high, done SHALL pulse for one cycle and the state SHALL become GAP.
REQ-017 GAP SHALL hold sync_n high and sclk low for MIN_GAP cycles, then return to IDLE.
REQ-018 sync_n SHALL stay low for exactly (50*CLK_DIV) cycles per frame.
REQ-019 Changes on data while busy SHALL NOT alter the frame in flight; only the value present on return to IDLE SHALL be sent next, and intermediate values are dropped.
REQ-020 If data returns to last_sent before IDLE is reached, no further frame SHALL be sent.
REQ-021 All outputs SHALL be registered, with no combinational path from data to sclk, mosi or sync_n.
REQ-022 Half-period, gap and bit counters SHALL saturate cleanly, with no wrap-around past their terminal counts.

Reset
REQ-023 While rst is high:
- sync_n=1, sclk=0, mosi=0, busy=0, done=0;
- state=IDLE, last_sent=16'h0000, send_pending=1.
REQ-024 Assertion of rst mid-frame SHALL abort the frame on the next clk edge, with sync_n high and no done pulse.
REQ-025 After rst deasserts, one frame SHALL always be sent with the current data, even if data equals 16'h0000.

Structure
REQ-026 A shared package SHALL hold:
- the state enumeration;
- the frame width constant 24;
- the default command constant 4'b0011.
REQ-027 The block SHALL be one module with one sub-module, dac_spi_timer: a half-period/gap down-counter producing a one-cycle tick.

Verification
REQ-028 Post-reset send: CLK_DIV=4, data=16'h8000 held -> the first frame carries 24'h308000, with sync_n low for 200 cycles, 24 sclk rises and one done pulse.
REQ-029 Steady input: data held constant after the first frame for 10000 cycles -> no further sync_n falling edge.
REQ-030 Mid-frame updates: data steps 0x1234 then 0x5678 then 0x9ABC during one frame -> exactly one following frame, carrying 24'h309ABC.
REQ-031 Revert before idle: data changes and returns to last_sent within one frame -> no extra frame after GAP.
REQ-032 Reset mid-frame: rst pulsed at the 10th sclk rise -> sync_n high on the next edge, no done pulse, and one frame with current data after release.
REQ-033 Gap timing: MIN_GAP=16 with continuous data changes -> sync_n high for exactly 16 cycles between consecutive frames, plus 1 IDLE cycle.
